// File: rtl/io_map_pkg.sv
// Memory-mapped I/O address map shared by the store buffer and the load mux:
// region bases, subregion codes and the byte-lane merge rule.
package io_map_pkg;

  localparam logic [15:0] IO_BASE_OUT = 16'h1000;
  localparam logic [15:0] IO_BASE_SW  = 16'h1001;
  localparam int          BTN_W       = 4;

  typedef enum logic [2:0] {
    REG_LEDR = 3'd0,
    REG_LEDG = 3'd1,
    REG_HEXL = 3'd2,
    REG_HEXH = 3'd3,
    REG_LCD  = 3'd4,
    REG_NONE = 3'd5
  } io_region_e;

  // Writable output subregion for an address; anything else is REG_NONE.
  function automatic io_region_e decode_region(input logic [31:0] addr);
    io_region_e region;
    region = REG_NONE;
    if (addr[31:16] == IO_BASE_OUT) begin
      case (addr[15:12])
        4'h0:    region = REG_LEDR;
        4'h1:    region = REG_LEDG;
        4'h2:    region = REG_HEXL;
        4'h3:    region = REG_HEXH;
        4'h4:    region = REG_LCD;
        default: region = REG_NONE;
      endcase
    end else if (addr[31:16] == IO_BASE_SW) begin
      region = REG_NONE;  // switch window is read-only
    end else begin
      region = REG_NONE;
    end
    return region;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (strb[n]) begin
        res[8*n +: 8] = data[8*n +: 8];
      end else begin
        res[8*n +: 8] = old_val[8*n +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus stable register for raw input pins.
// With IO_DEBOUNCE_EN defined, each bit only follows after DEBOUNCE_CYCLES stable cycles.
module io_debounce #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_stable
);

  logic [WIDTH-1:0] sync_1_q;
  logic [WIDTH-1:0] sync_2_q;
  logic [WIDTH-1:0] stable_q;

  // Metastability filter on the asynchronous pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1_q <= '0;
      sync_2_q <= '0;
    end else begin
      sync_1_q <= i_async;
      sync_2_q <= sync_1_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_d;

  // Per-bit mismatch counter; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Counter and stable-value state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // Undebounced: one register after the synchronizer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q <= '0;
    end else begin
      stable_q <= sync_2_q;
    end
  end
`endif

  assign o_stable = stable_q;

endmodule

// File: rtl/io_write_buffer.sv
// Store-side I/O buffers (LEDR/LEDG/HEXL/HEXH/LCD) and synchronized SW/BTN input buffers.
// Optional input debounce is selected with the IO_DEBOUNCE_EN macro.
module io_write_buffer
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_st_en,
  input  logic [31:0]       i_st_addr,
  input  logic [31:0]       i_st_data,
  input  logic [3:0]        i_st_strb,
  input  logic              f_io_valid,
  input  logic [31:0]       i_io_sw,
  input  logic [BTN_W-1:0]  i_io_btn,
  output logic [31:0]       b_io_ledr,
  output logic [31:0]       b_io_ledg,
  output logic [31:0]       b_io_hexl,
  output logic [31:0]       b_io_hexh,
  output logic [31:0]       b_io_lcd,
  output logic [31:0]       b_io_sw,
  output logic [31:0]       b_io_btn,
  output logic              o_st_err
);

  io_region_e  region_s;
  logic        st_valid_s;
  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] hexl_q, hexl_d;
  logic [31:0] hexh_q, hexh_d;
  logic [31:0] lcd_q,  lcd_d;
  logic        err_q,  err_d;
  logic [BTN_W-1:0] btn_stable_s;

  assign region_s   = decode_region(i_st_addr);
  assign st_valid_s = i_st_en & f_io_valid;

  // Lane merge into the addressed buffer; unmapped or read-only targets flag an error.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hexl_d = hexl_q;
    hexh_d = hexh_q;
    lcd_d  = lcd_q;
    err_d  = 1'b0;
    if (st_valid_s) begin
      case (region_s)
        REG_LEDR: ledr_d = merge_lanes(ledr_q, i_st_data, i_st_strb);
        REG_LEDG: ledg_d = merge_lanes(ledg_q, i_st_data, i_st_strb);
        REG_HEXL: hexl_d = merge_lanes(hexl_q, i_st_data, i_st_strb);
        REG_HEXH: hexh_d = merge_lanes(hexh_q, i_st_data, i_st_strb);
        REG_LCD:  lcd_d  = merge_lanes(lcd_q,  i_st_data, i_st_strb);
        default:  err_d  = 1'b1;
      endcase
    end else begin
      err_d = 1'b0;
    end
  end

  // Output buffers and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= 32'h0000_0000;
      ledg_q <= 32'h0000_0000;
      hexl_q <= 32'h0000_0000;
      hexh_q <= 32'h0000_0000;
      lcd_q  <= 32'h0000_0000;
      err_q  <= 1'b0;
    end else begin
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      hexl_q <= hexl_d;
      hexh_q <= hexh_d;
      lcd_q  <= lcd_d;
      err_q  <= err_d;
    end
  end

  io_debounce #(
    .WIDTH           (32),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_dbn (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_async  (i_io_sw),
    .o_stable (b_io_sw)
  );

  // Buttons are inverted before sync so a cleared flop means "not pressed".
  io_debounce #(
    .WIDTH           (BTN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_dbn (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_async  (~i_io_btn),
    .o_stable (btn_stable_s)
  );

  assign b_io_ledr = ledr_q;
  assign b_io_ledg = ledg_q;
  assign b_io_hexl = hexl_q;
  assign b_io_hexh = hexh_q;
  assign b_io_lcd  = lcd_q;
  assign b_io_btn  = {{(32-BTN_W){1'b0}}, btn_stable_s};
  assign o_st_err  = err_q;

endmodule

// File: tb/tb_io_write_buffer.sv
// Self-checking bench for io_write_buffer: directed store/error/input-latency steps
// followed by random stores (and random pins in the undebounced build) against a reference model.
module tb_io_write_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_st_en = 1'b0;
  logic [31:0] i_st_addr = 32'h0;
  logic [31:0] i_st_data = 32'h0;
  logic [3:0]  i_st_strb = 4'h0;
  logic        f_io_valid = 1'b0;
  logic [31:0] i_io_sw = 32'h0;
  logic [3:0]  i_io_btn = 4'hF;
  logic [31:0] b_io_ledr, b_io_ledg, b_io_hexl, b_io_hexh, b_io_lcd, b_io_sw, b_io_btn;
  logic        o_st_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_buf [5];
  logic        m_err;
  logic [31:0] sw_hist [$];
  logic [3:0]  btn_hist [$];

  io_write_buffer #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_st_en(i_st_en), .i_st_addr(i_st_addr),
    .i_st_data(i_st_data), .i_st_strb(i_st_strb), .f_io_valid(f_io_valid),
    .i_io_sw(i_io_sw), .i_io_btn(i_io_btn),
    .b_io_ledr(b_io_ledr), .b_io_ledg(b_io_ledg), .b_io_hexl(b_io_hexl),
    .b_io_hexh(b_io_hexh), .b_io_lcd(b_io_lcd), .b_io_sw(b_io_sw),
    .b_io_btn(b_io_btn), .o_st_err(o_st_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ledr", b_io_ledr, m_buf[0]);
    check("ledg", b_io_ledg, m_buf[1]);
    check("hexl", b_io_hexl, m_buf[2]);
    check("hexh", b_io_hexh, m_buf[3]);
    check("lcd",  b_io_lcd,  m_buf[4]);
    check("st_err", {31'h0, o_st_err}, {31'h0, m_err});
`ifndef IO_DEBOUNCE_EN
    check("sw",  b_io_sw,  (sw_hist.size() == 3) ? sw_hist[0] : 32'h0);
    check("btn", b_io_btn, (btn_hist.size() == 3) ? {28'h0, ~btn_hist[0]} : 32'h0);
`endif
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    int idx;
    @(posedge i_clk);
    if (!i_rst_n) begin
      for (int r = 0; r < 5; r++) m_buf[r] = 32'h0;
      m_err = 1'b0;
      sw_hist.delete();
      btn_hist.delete();
    end else begin
      m_err = 1'b0;
      if (i_st_en && f_io_valid) begin
        idx = int'(i_st_addr[15:12]);
        if (i_st_addr[31:16] == 16'h1000 && idx <= 4) begin
          for (int n = 0; n < 4; n++)
            if (i_st_strb[n]) m_buf[idx][8*n +: 8] = i_st_data[8*n +: 8];
        end else begin
          m_err = 1'b1;
        end
      end
      sw_hist.push_back(i_io_sw);
      btn_hist.push_back(i_io_btn);
      if (sw_hist.size() > 3) void'(sw_hist.pop_front());
      if (btn_hist.size() > 3) void'(btn_hist.pop_front());
    end
    #1;
    check_all();
  endtask

  task automatic rand_store();
    int unsigned sel;
    logic [15:0] hi;
    logic [3:0]  sub;
    sel = $urandom_range(0, 8);
    case (sel)
      0, 1, 2, 3, 4: begin
        sub = 4'(sel);
        i_st_addr = {16'h1000, sub, 12'($urandom)};
      end
      5: i_st_addr = {16'h1001, 16'($urandom)};
      6: begin
        sub = 4'($urandom_range(5, 15));
        i_st_addr = {16'h1000, sub, 12'($urandom)};
      end
      default: begin
        hi = 16'($urandom);
        if (hi == 16'h1000 || hi == 16'h1001) hi = 16'h2000;
        i_st_addr = {hi, 16'($urandom)};
      end
    endcase
    i_st_en    = ($urandom_range(0, 3) != 0);
    f_io_valid = ($urandom_range(0, 4) != 0);
    i_st_data  = $urandom;
    i_st_strb  = 4'($urandom);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic valid);
    i_st_en = 1'b1; i_st_addr = addr; i_st_data = data; i_st_strb = strb; f_io_valid = valid;
  endtask

  task automatic idle();
    i_st_en = 1'b0; f_io_valid = 1'b0; i_st_strb = 4'h0;
  endtask

  initial begin
    for (int r = 0; r < 5; r++) m_buf[r] = 32'h0;
    m_err = 1'b0;

    // Reset held with random activity on every input.
    for (int k = 0; k < 5; k++) begin
      rand_store();
      i_io_sw = $urandom; i_io_btn = 4'($urandom);
      tick();
    end
    idle(); i_io_sw = 32'h0; i_io_btn = 4'hF;
    tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Partial-lane write to HEXL.
    do_store(32'h1000_2000, 32'hAABB_CCDD, 4'b0101, 1'b1);
    tick();
    check("hexl_merge", b_io_hexl, 32'h00BB_00DD);
    idle(); tick();

    // Rejected stores and an I/O-invalid store.
    do_store(32'h1001_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    tick(); check("err_sw", {31'h0, o_st_err}, 32'h1);
    idle(); tick(); check("err_sw_drop", {31'h0, o_st_err}, 32'h0);
    do_store(32'h1000_7000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    tick(); check("err_unmapped", {31'h0, o_st_err}, 32'h1);
    idle(); tick(); check("hexl_after_err", b_io_hexl, 32'h00BB_00DD);
    do_store(32'h1000_0000, 32'h1234_5678, 4'hF, 1'b0);
    tick(); check("no_err_dmem", {31'h0, o_st_err}, 32'h0);
    check("ledr_dmem", b_io_ledr, 32'h0);
    do_store(32'h1000_1000, 32'h1234_5678, 4'h0, 1'b1);
    tick(); check("strb0_no_err", {31'h0, o_st_err}, 32'h0);

    // Back-to-back stores to LEDR; old value visible while the second is pending.
    do_store(32'h1000_0000, 32'h0000_0001, 4'hF, 1'b1);
    tick();
    do_store(32'h1000_0000, 32'h0000_FF00, 4'b0010, 1'b1);
    #1 check("ledr_same_cycle_load", b_io_ledr, 32'h0000_0001);
    tick();
    check("ledr_b2b", b_io_ledr, 32'h0000_FF01);
    idle(); tick();

`ifdef IO_DEBOUNCE_EN
    // Short press must be filtered.
    i_io_btn = 4'hE;
    for (int k = 0; k < 3; k++) tick();
    i_io_btn = 4'hF;
    for (int k = 0; k < 10; k++) begin
      tick(); check("btn_glitch", b_io_btn, 32'h0);
    end
    // Held press appears exactly six cycles after the edge.
    i_io_btn = 4'hE;
    for (int k = 1; k <= 6; k++) begin
      tick(); check("btn_hold", b_io_btn, (k == 6) ? 32'h1 : 32'h0);
    end
    i_io_btn = 4'hF;
    for (int k = 0; k < 10; k++) tick();
    check("btn_release", b_io_btn, 32'h0);
    // Reset in the middle of a count restarts it.
    i_io_btn = 4'hE;
    for (int k = 0; k < 3; k++) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(); check("btn_after_rst", b_io_btn, (k == 6) ? 32'h1 : 32'h0);
    end
    i_io_btn = 4'hF;
    for (int k = 0; k < 300; k++) begin
      rand_store();
      tick();
    end
`else
    // Three-cycle pin-to-buffer latency.
    i_io_sw = 32'h0000_0155;
    tick(); tick();
    check("sw_lat2", b_io_sw, 32'h0);
    tick();
    check("sw_lat3", b_io_sw, 32'h0000_0155);
    for (int k = 0; k < 300; k++) begin
      rand_store();
      i_io_sw = $urandom; i_io_btn = 4'($urandom);
      tick();
    end
`endif

    idle(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_write_buffer.md
Name: io_write_buffer

Overview:
- Store-side counterpart of the load mux: captures CPU stores into the memory-mapped output buffers (LEDR, LEDG, HEXL, HEXH, LCD).
- Samples the raw switch and button pins into the input buffers (SW, BTN).
- All b_io_* outputs feed the load mux and the top-level pins.
- Sits beside the LSU; stores commit one cycle after the request.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required before an input buffer bit changes (used only with IO_DEBOUNCE_EN).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_st_en  in  1  store request, single-cycle
- i_st_addr  in  32  store byte address
- i_st_data  in  32  store data, lane-aligned
- i_st_strb  in  4  byte-lane enables; bit n enables data[8n+7:8n]
- f_io_valid  in  1  address decoder flag: i_st_addr is in the I/O space
- i_io_sw  in  32  raw switch pins (asynchronous)
- i_io_btn  in  4  raw push buttons, active-low (0 = pressed)
- b_io_ledr, b_io_ledg, b_io_hexl, b_io_hexh, b_io_lcd  out  32 each  output buffers
- b_io_sw  out  32  synchronized switch buffer
- b_io_btn  out  32  button buffer; bits [3:0] = ~synced btn (1 = pressed), bits [31:4] = 0
- o_st_err  out  1  one-cycle pulse on a rejected store

Behaviour:
- Reset: i_rst_n low asynchronously clears every buffer, o_st_err, all sync flops and all debounce counters to 0.
- Release of i_rst_n is sampled on i_clk.
- A store commits when i_st_en & f_io_valid & mapped region, at the rising edge. The new value is visible on b_io_* the next cycle.
- Region decode:
  - i_st_addr[31:16]==16'h1000: bits [15:12] select 0=LEDR, 1=LEDG, 2=HEXL, 3=HEXH, 4=LCD.
  - 5..F: unmapped.
  - 16'h1001 (SW): read-only.
- Byte merge: for each n with i_st_strb[n]=1, buffer[8n+7:8n] <= i_st_data[8n+7:8n]. Other lanes hold. i_st_addr[1:0] is ignored; the LSU aligns lanes.
- i_st_strb==0 with a valid store: no write, no error.
- o_st_err pulses high for exactly 1 cycle, the cycle after the request, when i_st_en & f_io_valid and the target is one of:
  - the SW region;
  - an unmapped 0x1000 subregion;
  - addr[31:16] not in {1000,1001}.
  In all these cases no buffer changes.
- i_st_en with f_io_valid=0: ignored, no error (the store belongs to DMEM).
- Store and load to the same register in the same cycle: the load returns the old value. There is no bypass.
- Back-to-back stores: every cycle is accepted. The last write per lane wins in order.
- Input path: i_io_sw and ~i_io_btn pass through a 2-flop synchronizer. The total pin-to-buffer latency without debounce is 3 cycles (2 sync + 1 buffer register).
- Buffers b_io_sw and b_io_btn are not CPU-writable.

Optional Feature:
- IO_DEBOUNCE_EN defined:
  - Each synced input bit has a CNT_W counter.
  - If synced != buffer bit, the counter increments; when it reaches DEBOUNCE_CYCLES-1 the buffer bit takes the synced value and the counter clears.
  - If synced == buffer bit, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches the buffer. Latency = 2 + DEBOUNCE_CYCLES cycles.
  - Reset mid-count clears the counter.
- IO_DEBOUNCE_EN undefined: no counters; the buffer bit is the sync output, registered once.

Decomposition:
- Package io_map_pkg holds:
  - IO_BASE_OUT = 16'h1000 and IO_BASE_SW = 16'h1001;
  - the subregion codes as enum io_region_e {REG_LEDR, REG_LEDG, REG_HEXL, REG_HEXH, REG_LCD, REG_NONE};
  - the BTN_W = 4 constant.
- The load mux imports the same package.
- One sub-module, io_debounce, is parameterized by width and DEBOUNCE_CYCLES. It contains the sync, the counter and the stable register. It is instantiated once for SW (32 bits) and once for BTN (4 bits).

Test Plan:
- Reset: drive random pins and stores with i_rst_n=0 -> all b_io_*=0 and o_st_err=0. Deassert -> values stay 0 until stimulus.
- Store addr 0x1000_2000, data 0xAABBCCDD, strb 4'b0101 over HEXL=0 -> HEXL=0x00BB00DD next cycle. Pins hex0=0x5D, hex2=0x3B.
- Store to 0x1001_0000, then to 0x1000_7000 -> o_st_err pulses 1 cycle each and no buffer changes. Store with f_io_valid=0 -> no error.
- Back-to-back: LEDR word 0x1 then strb 4'b0010 data 0x0000FF00 -> LEDR=0x0000FF01 after 2 cycles. Same-cycle load returns the prior value.
- Debounce (IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4):
  - btn[0] low for 3 cycles then high -> b_io_btn stays 0.
  - btn[0] held low -> b_io_btn[0]=1 exactly 6 cycles after the edge.
  - Reset mid-count -> counter restarts.
- No-debounce build: i_io_sw toggles to 0x00000155 -> b_io_sw=0x155 exactly 3 cycles later.
